// File: rtl/fetch_ctrl.sv
// MIPS fetch sequencer: owns the PC, issues req/ready fetches, picks sequential/jump/branch next PC.
// Latency: inst_valid is combinational with the fetch handshake; a stalled word is held in a one-entry buffer.
// Backpressure: stall parks the word in HOLD with imem_req low. FETCH_ALIGN_CHECK_EN enables misaligned-target trapping.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0380
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data,
    output logic        addr_err
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] pend_q, pend_d;
    logic [31:0] hold_pc_q, hold_pc_d;
    logic [31:0] hold_data_q, hold_data_d;
    logic        err_q, err_d;

    logic        hs;
    logic        redirect;
    logic [31:0] raw_tgt;
    logic [31:0] clean_tgt;
    logic        misal;
    logic [31:0] tgt;
    logic [31:0] drain_tgt;

    assign hs       = req_q & imem_ready;
    assign redirect = branch_taken | jump;
    assign raw_tgt  = branch_taken ? branch_target : jump_target;

`ifdef FETCH_ALIGN_CHECK_EN
    assign misal     = (raw_tgt[1:0] != 2'b00);
    assign clean_tgt = raw_tgt;
`else
    assign misal     = 1'b0;
    assign clean_tgt = raw_tgt & ~32'h3;
`endif

    assign tgt       = misal ? EXC_VECTOR : clean_tgt;
    assign drain_tgt = redirect ? tgt : pend_q;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        addr_d      = addr_q;
        pend_d      = pend_q;
        hold_pc_d   = hold_pc_q;
        hold_data_d = hold_data_q;
        err_d       = 1'b0;
        inst_valid  = 1'b0;
        inst_pc     = hold_pc_q;
        inst_data   = hold_data_q;

        case (state_q)
            BOOT: begin
                state_d = FETCH;
                req_d   = 1'b1;
                addr_d  = RESET_PC;
            end
            FETCH: begin
                inst_pc   = addr_q;
                inst_data = imem_rdata;
                if (hs) begin
                    if (redirect) begin
                        addr_d = tgt;
                        err_d  = misal;
                    end else begin
                        inst_valid = 1'b1;
                        if (stall) begin
                            // Word is offered to decode now and kept for the HOLD cycles.
                            hold_pc_d   = addr_q;
                            hold_data_d = imem_rdata;
                            req_d       = 1'b0;
                            state_d     = HOLD;
                        end else begin
                            addr_d = addr_q + 32'd4;
                        end
                    end
                end else if (redirect) begin
                    // Request cannot be withdrawn: remember where to go once it completes.
                    pend_d  = tgt;
                    err_d   = misal;
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = FETCH;
                    req_d   = 1'b1;
                    addr_d  = tgt;
                    err_d   = misal;
                end else begin
                    inst_valid = 1'b1;
                    if (!stall) begin
                        state_d = FETCH;
                        req_d   = 1'b1;
                        addr_d  = hold_pc_q + 32'd4;
                    end
                end
            end
            DRAIN: begin
                pend_d = drain_tgt;
                err_d  = redirect & misal;
                if (hs) begin
                    state_d = FETCH;
                    addr_d  = drain_tgt;
                end
            end
            default: begin
                state_d = BOOT;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            req_q       <= 1'b0;
            addr_q      <= RESET_PC;
            pend_q      <= 32'h0;
            hold_pc_q   <= 32'h0;
            hold_data_q <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            addr_q      <= addr_d;
            pend_q      <= pend_d;
            hold_pc_q   <= hold_pc_d;
            hold_data_q <= hold_data_d;
            err_q       <= err_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign addr_err  = err_q;

endmodule
